// File: rtl/vending_purchase_fsm.sv
// Purchase controller: fetches the price, accumulates coins, dispenses once, then returns change or refunds.
// Select-to-COLLECT takes 2 cycles; no backpressure: strobes arriving outside their accepting state are dropped or rejected.
module vending_purchase_fsm #(
  parameter int PRICE_W  = 4,
  parameter int CREDIT_W = 5,
  parameter int TIMEOUT  = 255
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic                select,
  input  logic [2:0]          productCode,
  output logic [2:0]          priceAddr,
  input  logic [PRICE_W-1:0]  price,
  input  logic                coinValid,
  input  logic [1:0]          coinValue,
  input  logic                cancel,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit,
  output logic                coinReject,
  output logic                dispense,
  output logic [2:0]          dispenseCode,
  output logic                changeValid,
  output logic [CREDIT_W-1:0] changeAmount,
  output logic                refunded
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, COLLECT, DISPENSE, CHANGE, REFUND} state_t;

  state_t              state;
  logic [2:0]          selReg;
  logic [PRICE_W-1:0]  priceReg;
  logic [TW-1:0]       timer;
  logic [CREDIT_W-1:0] coinAmt;
  logic [CREDIT_W-1:0] sum;
  logic [CREDIT_W-1:0] newCredit;
  logic [CREDIT_W-1:0] priceExt;
  logic                coinOk;
  logic                timedOut;

  always_comb begin
    case (coinValue)
      2'b01:   coinAmt = CREDIT_W'(1);
      2'b10:   coinAmt = CREDIT_W'(2);
      2'b11:   coinAmt = CREDIT_W'(5);
      default: coinAmt = '0;
    endcase
  end

  assign coinOk    = coinValid && (coinValue != 2'b00);
  assign sum       = credit + coinAmt;
  // A coin landing together with cancel is counted before the refund.
  assign newCredit = coinOk ? sum : credit;
  assign priceExt  = CREDIT_W'(priceReg);
  assign timedOut  = !coinOk && (timer == TW'(TIMEOUT - 1));
  assign busy      = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state        <= IDLE;
      selReg       <= '0;
      priceReg     <= '0;
      timer        <= '0;
      credit       <= '0;
      priceAddr    <= '0;
      coinReject   <= 1'b0;
      dispense     <= 1'b0;
      dispenseCode <= '0;
      changeValid  <= 1'b0;
      changeAmount <= '0;
      refunded     <= 1'b0;
    end else begin
      coinReject  <= coinValid && !(state == COLLECT && coinValue != 2'b00);
      dispense    <= 1'b0;
      changeValid <= 1'b0;
      refunded    <= 1'b0;
      case (state)
        IDLE: begin
          if (select) begin
            selReg    <= productCode;
            priceAddr <= productCode;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          priceReg <= price;
          timer    <= '0;
          if (price == '0) begin
            state        <= DISPENSE;
            dispense     <= 1'b1;
            dispenseCode <= selReg;
          end else begin
            state <= COLLECT;
          end
        end
        COLLECT: begin
          if (coinOk) begin
            credit <= sum;
            timer  <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
          if (cancel || timedOut) begin
            state <= REFUND;
            if (newCredit != '0) begin
              changeValid  <= 1'b1;
              refunded     <= 1'b1;
              changeAmount <= newCredit;
            end
          end else if (coinOk && sum >= priceExt) begin
            state        <= DISPENSE;
            dispense     <= 1'b1;
            dispenseCode <= selReg;
          end
        end
        DISPENSE: begin
          if (credit > priceExt) begin
            state        <= CHANGE;
            changeValid  <= 1'b1;
            changeAmount <= credit - priceExt;
          end else begin
            state  <= IDLE;
            credit <= '0;
          end
        end
        CHANGE, REFUND: begin
          state  <= IDLE;
          credit <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_purchase_fsm.sv
// Bench for vending_purchase_fsm: directed vector table, timeout sequence, and random purchases against a transaction model.
module tb_vending_purchase_fsm;

  localparam int TMO = 10;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic       select = 1'b0;
  logic [2:0] productCode = '0;
  logic [2:0] priceAddr;
  logic [3:0] price;
  logic       coinValid = 1'b0;
  logic [1:0] coinValue = '0;
  logic       cancel = 1'b0;
  logic       busy;
  logic [4:0] credit;
  logic       coinReject;
  logic       dispense;
  logic [2:0] dispenseCode;
  logic       changeValid;
  logic [4:0] changeAmount;
  logic       refunded;

  logic [3:0] priceTab [8];
  assign price = priceTab[priceAddr];

  always #5 clock = ~clock;

  vending_purchase_fsm #(.PRICE_W(4), .CREDIT_W(5), .TIMEOUT(TMO)) dut (
    .clock(clock), .resetN(resetN), .select(select), .productCode(productCode),
    .priceAddr(priceAddr), .price(price), .coinValid(coinValid), .coinValue(coinValue),
    .cancel(cancel), .busy(busy), .credit(credit), .coinReject(coinReject),
    .dispense(dispense), .dispenseCode(dispenseCode), .changeValid(changeValid),
    .changeAmount(changeAmount), .refunded(refunded)
  );

  typedef struct {
    logic       rst, sel;
    logic [2:0] code;
    logic       cv;
    logic [1:0] cval;
    logic       can;
    logic       busy;
    logic [4:0] credit;
    logic       rej, disp;
    logic [2:0] dcode;
    logic       chv;
    logic [4:0] chamt;
    logic       refd;
  } vec_t;

  vec_t vecs [39];
  int nChecks = 0;
  int nFail = 0;
  int nDisp, nChg, nRej, lastCode, lastAmt, lastRef;

  function automatic vec_t mk(int rst, int sel, int code, int cv, int cval, int can,
                              int b, int cr, int rej, int disp, int dc, int chv, int amt, int rf);
    vec_t v;
    v.rst = rst[0]; v.sel = sel[0]; v.code = code[2:0]; v.cv = cv[0]; v.cval = cval[1:0];
    v.can = can[0]; v.busy = b[0]; v.credit = cr[4:0]; v.rej = rej[0]; v.disp = disp[0];
    v.dcode = dc[2:0]; v.chv = chv[0]; v.chamt = amt[4:0]; v.refd = rf[0];
    return v;
  endfunction

  function automatic int coinUnits(int v);
    return (v == 1) ? 1 : (v == 2) ? 2 : (v == 3) ? 5 : 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int sel, input int code, input int cv, input int cval, input int can);
    select = sel[0]; productCode = code[2:0]; coinValid = cv[0]; coinValue = cval[1:0]; cancel = can[0];
  endtask

  // One clock: inputs were set after the previous falling edge, outputs sampled at the next one.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
    if (dispense) begin nDisp++; lastCode = int'(dispenseCode); end
    if (changeValid) begin nChg++; lastAmt = int'(changeAmount); lastRef = int'(refunded); end
    if (coinReject) nRej++;
  endtask

  initial begin
    int p, pr, cr, idle, g, v, c, nEv, kHit, rejSeen;
    int expDisp, expChg, expAmt, expRef, expRej;
    int evGap [16];
    int evVal [16];
    int evCan [16];
    bit done;

    priceTab[0] = 4'd3; priceTab[1] = 4'd0; priceTab[2] = 4'd9; priceTab[3] = 4'd5;
    priceTab[4] = 4'd2; priceTab[5] = 4'd7; priceTab[6] = 4'd1; priceTab[7] = 4'd15;

    //          rst sel cd cv cval can | busy cr rej disp dc chv amt ref
    vecs[0]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 4, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0, 1, 1, 0,  1, 1, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 0, 0, 1, 1, 0,  1, 2, 0, 1, 4, 0, 0, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4, 0, 0, 0);
    vecs[6]  = mk(1, 1, 4, 0, 0, 0,  1, 0, 0, 0, 4, 0, 0, 0);
    vecs[7]  = mk(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4, 0, 0, 0);
    vecs[8]  = mk(1, 0, 0, 1, 3, 0,  1, 5, 0, 1, 4, 0, 0, 0);
    vecs[9]  = mk(1, 0, 0, 0, 0, 0,  1, 5, 0, 0, 4, 1, 3, 0);
    vecs[10] = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4, 0, 3, 0);
    vecs[11] = mk(1, 1, 5, 0, 0, 0,  1, 0, 0, 0, 4, 0, 3, 0);
    vecs[12] = mk(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4, 0, 3, 0);
    vecs[13] = mk(1, 0, 0, 1, 2, 0,  1, 2, 0, 0, 4, 0, 3, 0);
    vecs[14] = mk(1, 0, 0, 1, 2, 0,  1, 4, 0, 0, 4, 0, 3, 0);
    vecs[15] = mk(1, 0, 0, 0, 0, 1,  1, 4, 0, 0, 4, 1, 4, 1);
    vecs[16] = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4, 0, 4, 0);
    vecs[17] = mk(1, 1, 5, 0, 0, 1,  1, 0, 0, 0, 4, 0, 4, 0);
    vecs[18] = mk(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4, 0, 4, 0);
    vecs[19] = mk(1, 0, 0, 1, 3, 0,  1, 5, 0, 0, 4, 0, 4, 0);
    vecs[20] = mk(1, 0, 0, 1, 1, 1,  1, 6, 0, 0, 4, 1, 6, 1);
    vecs[21] = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4, 0, 6, 0);
    vecs[22] = mk(1, 0, 0, 1, 2, 0,  0, 0, 1, 0, 4, 0, 6, 0);
    vecs[23] = mk(1, 1, 1, 0, 0, 0,  1, 0, 0, 0, 4, 0, 6, 0);
    vecs[24] = mk(1, 0, 0, 1, 1, 0,  1, 0, 1, 1, 1, 0, 6, 0);
    vecs[25] = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 6, 0);
    vecs[26] = mk(1, 1, 3, 0, 0, 0,  1, 0, 0, 0, 1, 0, 6, 0);
    vecs[27] = mk(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 6, 0);
    vecs[28] = mk(1, 1, 6, 1, 3, 0,  1, 5, 0, 1, 3, 0, 6, 0);
    vecs[29] = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3, 0, 6, 0);
    vecs[30] = mk(1, 1, 3, 0, 0, 0,  1, 0, 0, 0, 3, 0, 6, 0);
    vecs[31] = mk(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 3, 0, 6, 0);
    vecs[32] = mk(1, 0, 0, 1, 2, 0,  1, 2, 0, 0, 3, 0, 6, 0);
    vecs[33] = mk(1, 0, 0, 1, 1, 0,  1, 3, 0, 0, 3, 0, 6, 0);
    vecs[34] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    vecs[35] = mk(1, 1, 4, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    vecs[36] = mk(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    vecs[37] = mk(1, 0, 0, 1, 2, 0,  1, 2, 0, 1, 4, 0, 0, 0);
    vecs[38] = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4, 0, 0, 0);

    for (int i = 0; i < 39; i++) begin
      resetN = vecs[i].rst;
      drive(int'(vecs[i].sel), int'(vecs[i].code), int'(vecs[i].cv), int'(vecs[i].cval), int'(vecs[i].can));
      step();
      chk($sformatf("v%0d.busy", i), int'(busy), int'(vecs[i].busy));
      chk($sformatf("v%0d.credit", i), int'(credit), int'(vecs[i].credit));
      chk($sformatf("v%0d.coinReject", i), int'(coinReject), int'(vecs[i].rej));
      chk($sformatf("v%0d.dispense", i), int'(dispense), int'(vecs[i].disp));
      chk($sformatf("v%0d.dispenseCode", i), int'(dispenseCode), int'(vecs[i].dcode));
      chk($sformatf("v%0d.changeValid", i), int'(changeValid), int'(vecs[i].chv));
      chk($sformatf("v%0d.changeAmount", i), int'(changeAmount), int'(vecs[i].chamt));
      chk($sformatf("v%0d.refunded", i), int'(refunded), int'(vecs[i].refd));
      if (i == 0) chk("reset.priceAddr", int'(priceAddr), 0);
      if (i == 1) chk("lookup.priceAddr", int'(priceAddr), 4);
    end
    drive(0, 0, 0, 0, 0);

    // Timeout: one coin, then silence with an invalid coin mid-wait; refund after TMO idle cycles.
    drive(1, 3, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0); step();
    drive(0, 0, 1, 1, 0); step();
    chk("tmo.credit", int'(credit), 1);
    nDisp = 0; kHit = -1; rejSeen = 0;
    for (int k = 1; k <= 40 && kHit < 0; k++) begin
      if (k == 4) drive(0, 0, 1, 0, 0); else drive(0, 0, 0, 0, 0);
      step();
      if (k == 4) rejSeen = int'(coinReject);
      if (dispense) nDisp++;
      if (changeValid) begin
        kHit = k;
        chk("tmo.amount", int'(changeAmount), 1);
        chk("tmo.refunded", int'(refunded), 1);
      end
    end
    chk("tmo.cycles", kHit, TMO);
    chk("tmo.invalidReject", rejSeen, 1);
    chk("tmo.noDispense", nDisp, 0);
    drive(0, 0, 0, 0, 0);
    repeat (3) step();
    chk("tmo.idle", int'(busy), 0);

    // Random purchases against a transaction-level model.
    for (int t = 0; t < 150; t++) begin
      p  = $urandom_range(0, 7);
      pr = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
      priceTab[p] = pr[3:0];
      cr = 0; idle = 0; done = 0; nEv = 0;
      expDisp = 0; expChg = 0; expAmt = 0; expRef = 0; expRej = 0;
      if (pr == 0) begin
        expDisp = 1; done = 1;
      end
      while (!done && nEv < 16) begin
        g = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 3);
        v = $urandom_range(0, 3);
        c = ($urandom_range(0, 7) == 0) ? 1 : 0;
        if (idle + g >= TMO) begin
          done = 1;
          if (cr > 0) begin expChg = 1; expAmt = cr; expRef = 1; end
        end else begin
          idle += g;
          if (v != 0) begin cr += coinUnits(v); idle = 0; end
          else begin expRej++; idle++; end
          if (v != 0 && cr >= pr) c = 0;
          evGap[nEv] = g; evVal[nEv] = v; evCan[nEv] = c; nEv++;
          if (c != 0 || (v == 0 && idle >= TMO)) begin
            done = 1;
            if (cr > 0) begin expChg = 1; expAmt = cr; expRef = 1; end
          end else if (v != 0 && cr >= pr) begin
            done = 1; expDisp = 1;
            if (cr > pr) begin expChg = 1; expAmt = cr - pr; expRef = 0; end
          end
        end
      end
      if (!done && cr > 0) begin expChg = 1; expAmt = cr; expRef = 1; end

      nDisp = 0; nChg = 0; nRej = 0; lastCode = -1; lastAmt = -1; lastRef = -1;
      drive(1, p, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0); step();
      for (int e = 0; e < nEv; e++) begin
        drive(0, 0, 0, 0, 0);
        repeat (evGap[e]) step();
        drive(0, 0, 1, evVal[e], evCan[e]); step();
      end
      drive(0, 0, 0, 0, 0);
      repeat (TMO + 6) step();

      chk($sformatf("rnd%0d.dispenseCount", t), nDisp, expDisp);
      if (expDisp != 0) chk($sformatf("rnd%0d.dispenseCode", t), lastCode, p);
      chk($sformatf("rnd%0d.changeCount", t), nChg, expChg);
      if (expChg != 0) begin
        chk($sformatf("rnd%0d.changeAmount", t), lastAmt, expAmt);
        chk($sformatf("rnd%0d.refunded", t), lastRef, expRef);
      end
      chk($sformatf("rnd%0d.rejects", t), nRej, expRej);
      chk($sformatf("rnd%0d.idle", t), int'(busy), 0);
      chk($sformatf("rnd%0d.creditCleared", t), int'(credit), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/vending_purchase_fsm.md
Name: vending_purchase_fsm

Overview:
Transaction controller that sits directly downstream of the price-table/change-price stage. It fetches the current price of the selected product from that stage over a 3-bit address, accumulates inserted coins, and issues one dispense pulse. It then returns change, or refunds the full credit on cancel or timeout. Its outputs drive the dispenser and change-return logic.

Parameters:
PRICE_W, 4, width of price bus from price stage
CREDIT_W, 5, width of credit accumulator and change/refund amount
TIMEOUT, 255, idle cycles in COLLECT before automatic refund (≥1)

Ports:
clock  in  1  system clock, rising edge
resetN  in  1  synchronous active-low reset
select  in  1  one-cycle request to buy productCode
productCode  in  3  product index, sampled with select
priceAddr  out  3  product index presented to price stage
price  in  PRICE_W  price for priceAddr, combinational from price stage
coinValid  in  1  one-cycle coin-inserted strobe
coinValue  in  2  01=1, 10=2, 11=5 units; 00 = invalid coin
cancel  in  1  one-cycle user cancel
busy  out  1  high whenever state != IDLE
credit  out  CREDIT_W  current accumulated credit
coinReject  out  1  one-cycle pulse: coin not accepted
dispense  out  1  one-cycle pulse: release product
dispenseCode  out  3  product index, valid with dispense
changeValid  out  1  one-cycle pulse: return changeAmount
changeAmount  out  CREDIT_W  amount to return, valid with changeValid
refunded  out  1  one-cycle pulse with changeValid on cancel/timeout

Behaviour:
Clock and reset:
- Single clock domain. Reset sampled only at the rising edge while resetN=0, including mid-transaction.
- On reset: state=IDLE; credit=0; all pulses (coinReject, dispense, changeValid, refunded) are 0; priceAddr=0; dispenseCode=0; changeAmount=0; timeout counter=0. Credit held at reset is discarded, with no refund pulse.

States: IDLE, LOOKUP, COLLECT, DISPENSE, CHANGE, REFUND.
- IDLE: select=1 latches productCode into selReg and moves to LOOKUP. A coinValid in IDLE gives coinReject the next cycle, and credit is unchanged.
- LOOKUP, one cycle: priceAddr=selReg, and price is registered into priceReg. Next state is DISPENSE if price==0, otherwise COLLECT. Select-to-COLLECT latency is 2 cycles.
- COLLECT: on coinValid with a valid code, credit <= credit + value and the timeout counter is cleared.
  - If credit+value ≥ priceReg, next state is DISPENSE.
  - coinValue=00 gives a coinReject pulse, credit is unchanged, and the timeout counter is not cleared.
  - cancel=1 gives next state REFUND. If coinValid and cancel arrive in the same cycle, the coin is accepted first and the refund includes it.
  - Counter reaching TIMEOUT with no valid coin gives next state REFUND.
- DISPENSE, one cycle: dispense=1 and dispenseCode=selReg. Next state is CHANGE if credit>priceReg, otherwise IDLE with credit cleared.
- CHANGE, one cycle: changeValid=1, changeAmount=credit-priceReg, refunded=0. Next state is IDLE with credit cleared.
- REFUND, one cycle: if credit>0, changeValid=1, refunded=1, changeAmount=credit; if credit==0, no pulses. Next state is IDLE with credit cleared.
- busy is combinational from state. A select received while busy is ignored and not queued. cancel outside COLLECT is ignored. Coins arriving in LOOKUP, DISPENSE, CHANGE or REFUND give coinReject.

Arithmetic and widths:
- All arithmetic is unsigned. With PRICE_W=4 and a maximum coin of 5, credit never exceeds 19, so CREDIT_W=5 cannot overflow.
- Parameter requirement: CREDIT_W ≥ bit width of (2^PRICE_W - 1 + 5).
- changeAmount holds its last value between pulses.

Test Plan:
- Reset, then select with productCode=4 and price stage returning 2; insert coin 01 twice → dispense one cycle after the second coin, dispenseCode=4, no changeValid, busy drops the next cycle, credit=0.
- Product 4 at price 2, insert one coin 11 → dispense, then changeValid with changeAmount=3 and refunded=0 on the next cycle.
- Price 7, insert 10 then 10, then cancel → changeValid=1, refunded=1, changeAmount=4, no dispense; a coinValid arriving together with the cancel raises changeAmount to include that coin.
- TIMEOUT=10, price 5, insert 01, then no activity → refund of 1 after 10 idle cycles. An invalid coin 00 mid-wait gives coinReject and does not extend the wait.
- Price 0 → dispense 2 cycles after select with no coin. A coin in IDLE gives coinReject and credit stays 0. A select during COLLECT does not change dispenseCode.
- Credit 3 of price 5, then resetN=0 for one cycle → state IDLE, credit=0, no changeValid; the next select works normally.
